// File: rtl/display_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
//   scan_state_e : controller FSM states
//   SEG_OFF      : all segments dark (active-low)
//   SEG_DASH     : "-" glyph, shown for non-BCD codes 10-15
//   SEG_GLYPHS   : active-low {g,f,e,d,c,b,a} glyphs for digits 0-9
package display_scan_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } scan_state_e;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Entry n is the glyph for digit n (index 9 is listed first).
  localparam logic [9:0][6:0] SEG_GLYPHS = {
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to common-anode 7-segment decoder.
//   bcd_i : 4-bit code; 0-9 map to glyphs, 10-15 map to a dash
//   seg_o : active-low segments {g,f,e,d,c,b,a}
module seg7_decoder
  import display_scan_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (bcd_i <= 4'd9) begin
      seg_o = SEG_GLYPHS[bcd_i];
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS BCD digits on a shared common-anode
// 7-segment bus. The raw Sel strobe from the clock divider is synchronised and its rising
// edges advance the scan; each digit is preceded by BLANK_CYCLES clocks with all anodes off.
//   clock     : system clock, rising edge
//   reset     : asynchronous, active-high
//   sel_in    : raw divider strobe (asynchronous to clock)
//   enable    : 1 = scan, 0 = display dark
//   digits    : packed BCD digits, digit i = digits[4i+3:4i], digit 0 least significant
//   anodes    : active-low digit enables, one-hot-low or all ones
//   segments  : active-low {g,f,e,d,c,b,a}
//   digit_idx : index of the currently selected digit
// Build option: define SCAN_LZ_BLANK_EN to suppress leading zeros on digits above digit 0.
module display_scan_ctrl
  import display_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned BLANK_CYCLES = 4,
  localparam int unsigned IdxW        = $clog2(NUM_DIGITS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sel_in,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [6:0]              segments,
  output logic [IdxW-1:0]         digit_idx
);

  localparam logic [7:0]      BlankLoad = 8'(BLANK_CYCLES - 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_DIGITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   step;

  scan_state_e            state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [NUM_DIGITS-1:0]  anodes_q, anodes_d;
  logic [6:0]             seg_q, seg_d;

  logic [3:0]             cur_digit;
  logic [6:0]             dec_seg;
  logic [6:0]             show_seg;

  // Synchroniser plus one flop for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sel_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign step = sync_q[SYNC_STAGES-1] & ~prev_q;

  assign cur_digit = digits[{idx_q, 2'b00} +: 4];

  seg7_decoder u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

`ifdef SCAN_LZ_BLANK_EN
  logic upper_zero;

  // Digit idx_q and everything above it are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if (j >= 32'(idx_q) && digits[4*j +: 4] != 4'd0) begin
        upper_zero = 1'b0;
      end
    end
  end

  assign show_seg = (upper_zero && idx_q != '0) ? SEG_OFF : dec_seg;
`else
  assign show_seg = dec_seg;
`endif

  // Next-state logic. enable low overrides everything, including a coincident step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          cnt_d   = BlankLoad;
        end
        StBlank: begin
          // Steps arriving here are dropped on purpose.
          if (cnt_q == 8'd0) begin
            state_d = StShow;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        StShow: begin
          if (step) begin
            idx_d   = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
            state_d = StBlank;
            cnt_d   = BlankLoad;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Registered outputs derived from the next state. The glyph is captured once on entry
  // to SHOW (always from BLANK) and then held, so mid-digit input changes are ignored.
  always_comb begin
    anodes_d = '1;
    seg_d    = SEG_OFF;
    if (state_d == StShow) begin
      anodes_d[idx_d] = 1'b0;
      seg_d           = (state_q == StShow) ? seg_q : show_seg;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      idx_q    <= '0;
      anodes_q <= '1;
      seg_q    <= SEG_OFF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      anodes_q <= anodes_d;
      seg_q    <= seg_d;
    end
  end

  assign anodes    = anodes_q;
  assign segments  = seg_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (NUM_DIGITS=4, SYNC_STAGES=2, BLANK_CYCLES=4).
// Honours SCAN_LZ_BLANK_EN when the same define is used for the build.
module tb_display_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel_in;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic [1:0]  digit_idx;

  int n_checks = 0;
  int n_errors = 0;
  int m_idx    = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] idx;
  } scan_vec_t;

  typedef struct packed {
    logic [3:0] nib;
    logic [6:0] seg;
  } dec_vec_t;

  scan_vec_t scan_tab [4];
  dec_vec_t  dec_tab  [16];

  display_scan_ctrl #(
    .NUM_DIGITS   (4),
    .SYNC_STAGES  (2),
    .BLANK_CYCLES (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .sel_in    (sel_in),
    .enable    (enable),
    .digits    (digits),
    .anodes    (anodes),
    .segments  (segments),
    .digit_idx (digit_idx)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] glyph(logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(logic [15:0] d, int i);
    logic [6:0] g;
    g = glyph(d[4*i +: 4]);
`ifdef SCAN_LZ_BLANK_EN
    begin
      bit z;
      z = 1'b1;
      for (int j = i; j < 4; j++) if (d[4*j +: 4] != 4'd0) z = 1'b0;
      if (i != 0 && z) g = 7'h7F;
    end
`endif
    return g;
  endfunction

  function automatic logic [3:0] an_of(int i);
    logic [3:0] a;
    a    = 4'hF;
    a[i] = 1'b0;
    return a;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(string name, logic [3:0] an, logic [6:0] sg, logic [1:0] ix);
    check({name, " anodes"}, 32'(anodes), 32'(an));
    check({name, " segments"}, 32'(segments), 32'(sg));
    check({name, " digit_idx"}, 32'(digit_idx), 32'(ix));
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One clean sel_in pulse from a stable SHOW: step lands on the 3rd edge, then 4 blank
  // clocks, then the next digit appears on the 7th edge.
  task automatic do_step(string name, logic [3:0] exp_an, logic [6:0] exp_sg);
    sel_in = 1'b1;
    tick(2);
    check({name, " pre"}, 32'(anodes), 32'(an_of(m_idx)));
    tick(1);
    m_idx = (m_idx + 1) % 4;
    check_out({name, " blank"}, 4'hF, 7'h7F, 2'(m_idx));
    sel_in = 1'b0;
    tick(3);
    check({name, " blank end"}, 32'(anodes), 32'hF);
    tick(1);
    check_out(name, exp_an, exp_sg, 2'(m_idx));
  endtask

  initial begin
    scan_tab[0] = '{an: 4'b1101, seg: 7'h30, idx: 2'd1};
    scan_tab[1] = '{an: 4'b1011, seg: 7'h24, idx: 2'd2};
    scan_tab[2] = '{an: 4'b0111, seg: 7'h79, idx: 2'd3};
    scan_tab[3] = '{an: 4'b1110, seg: 7'h19, idx: 2'd0};

    dec_tab[0]  = '{nib: 4'h0, seg: 7'h40};
    dec_tab[1]  = '{nib: 4'h1, seg: 7'h79};
    dec_tab[2]  = '{nib: 4'h2, seg: 7'h24};
    dec_tab[3]  = '{nib: 4'h3, seg: 7'h30};
    dec_tab[4]  = '{nib: 4'h4, seg: 7'h19};
    dec_tab[5]  = '{nib: 4'h5, seg: 7'h12};
    dec_tab[6]  = '{nib: 4'h6, seg: 7'h02};
    dec_tab[7]  = '{nib: 4'h7, seg: 7'h78};
    dec_tab[8]  = '{nib: 4'h8, seg: 7'h00};
    dec_tab[9]  = '{nib: 4'h9, seg: 7'h10};
    dec_tab[10] = '{nib: 4'hA, seg: 7'h3F};
    dec_tab[11] = '{nib: 4'hB, seg: 7'h3F};
    dec_tab[12] = '{nib: 4'hC, seg: 7'h3F};
    dec_tab[13] = '{nib: 4'hD, seg: 7'h3F};
    dec_tab[14] = '{nib: 4'hE, seg: 7'h3F};
    dec_tab[15] = '{nib: 4'hF, seg: 7'h3F};

    reset  = 1'b1;
    sel_in = 1'b0;
    enable = 1'b0;
    digits = 16'h0000;
    #2;
    check_out("reset", 4'hF, 7'h7F, 2'd0);

    // Disabled after reset: stays dark.
    tick(1);
    reset = 1'b0;
    tick(3);
    check_out("idle", 4'hF, 7'h7F, 2'd0);

    // Test 1: enable -> 4 blank clocks -> digit 0.
    digits = 16'h1234;
    enable = 1'b1;
    tick(4);
    check("t1 blank", 32'(anodes), 32'hF);
    tick(1);
    check_out("t1 show", 4'b1110, 7'h19, 2'd0);
    m_idx = 0;

    // Test 2: full scan rotation, table driven.
    for (int k = 0; k < 4; k++) begin
      do_step("t2", scan_tab[k].an, scan_tab[k].seg);
      check("t2 table idx", 32'(digit_idx), 32'(scan_tab[k].idx));
    end

    // Decoder coverage through the live scan, one code per step.
    for (int k = 0; k < 16; k++) begin
      int         nxt;
      logic [6:0] es;
      digits = {4{dec_tab[k].nib}};
      nxt    = (m_idx + 1) % 4;
      es     = dec_tab[k].seg;
`ifdef SCAN_LZ_BLANK_EN
      if (dec_tab[k].nib == 4'h0 && nxt != 0) es = 7'h7F;
`endif
      do_step("dec", an_of(nxt), es);
    end

    // Test 3: non-BCD dash and leading zeros.
    digits = 16'h00A7;
    for (int k = 0; k < 4; k++) begin
      int nxt;
      nxt = (m_idx + 1) % 4;
      do_step("t3 00A7", an_of(nxt), exp_seg(16'h00A7, nxt));
    end
    digits = 16'h0007;
    for (int k = 0; k < 4; k++) begin
      int nxt;
      nxt = (m_idx + 1) % 4;
      do_step("t3 0007", an_of(nxt), exp_seg(16'h0007, nxt));
    end

    // Test 4a: digits change mid-SHOW (digit 0 showing "7").
    digits = 16'h5555;
    tick(3);
    check_out("t4 hold", 4'b1110, 7'h78, 2'd0);

    // Test 4b: second sel_in rise lands inside BLANK, must not advance again.
    digits = 16'h1234;
    sel_in = 1'b1;
    tick(1);
    sel_in = 1'b0;
    tick(2);
    check_out("t4 blank", 4'hF, 7'h7F, 2'd1);
    sel_in = 1'b1;
    tick(3);
    check_out("t4 blank2", 4'hF, 7'h7F, 2'd1);
    tick(1);
    check_out("t4 show", 4'b1101, 7'h30, 2'd1);
    tick(4);
    check_out("t4 stay", 4'b1101, 7'h30, 2'd1);
    sel_in = 1'b0;
    tick(3);
    m_idx = 1;

    // Test 5: disable while showing digit 2, then re-enable.
    do_step("t5 to2", 4'b1011, 7'h24);
    enable = 1'b0;
    tick(1);
    check_out("t5 off", 4'hF, 7'h7F, 2'd2);
    tick(3);
    check_out("t5 off hold", 4'hF, 7'h7F, 2'd2);
    enable = 1'b1;
    tick(4);
    check("t5 reblank", 32'(anodes), 32'hF);
    tick(1);
    check_out("t5 reshow", 4'b1011, 7'h24, 2'd2);

    // enable falls on the same edge the step is sampled: no advance.
    sel_in = 1'b1;
    tick(2);
    enable = 1'b0;
    tick(1);
    check_out("t5 race", 4'hF, 7'h7F, 2'd2);
    tick(2);
    sel_in = 1'b0;
    tick(3);
    enable = 1'b1;
    tick(4);
    check("t5 race blank", 32'(anodes), 32'hF);
    tick(1);
    check_out("t5 race show", 4'b1011, 7'h24, 2'd2);

    // Test 6: asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    check_out("t6 async", 4'hF, 7'h7F, 2'd0);
    #1;
    reset = 1'b0;
    tick(4);
    check("t6 blank", 32'(anodes), 32'hF);
    tick(1);
    check_out("t6 show", 4'b1110, 7'h19, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
